// File: rtl/fixed_point_divider_if.sv
// -----------------------------------------------------------------------------
// fixed_point_divider_if
// Operand/result handshake bundle for fixed_point_divider.
//   a, b        : unsigned dividend / divisor (WORD_LENGTH bits)
//   valid_i     : operand strobe, ready_o : divider can accept operands
//   quotient    : floor(a*2^FRAC_BITS / b), Q_W bits
//   remainder   : (a*2^FRAC_BITS) mod b, WORD_LENGTH bits
//   div_by_zero : result was produced with b == 0
//   valid_o     : result valid, ready_i : downstream accepts result
// The master modport belongs to whoever issues operands, the slave modport to
// the divider itself.
// -----------------------------------------------------------------------------
interface fixed_point_divider_if #(
    parameter int WORD_LENGTH = 16,
    parameter int FRAC_BITS   = 8
);
    localparam int Q_W = WORD_LENGTH + FRAC_BITS;

    logic [WORD_LENGTH-1:0] a;
    logic [WORD_LENGTH-1:0] b;
    logic                   valid_i;
    logic                   ready_o;
    logic [Q_W-1:0]         quotient;
    logic [WORD_LENGTH-1:0] remainder;
    logic                   div_by_zero;
    logic                   valid_o;
    logic                   ready_i;

    modport master (
        output a, b, valid_i, ready_i,
        input  ready_o, quotient, remainder, div_by_zero, valid_o
    );

    modport slave (
        input  a, b, valid_i, ready_i,
        output ready_o, quotient, remainder, div_by_zero, valid_o
    );
endinterface

// File: rtl/fixed_point_divider.sv
// -----------------------------------------------------------------------------
// fixed_point_divider
// Sequential radix-2 restoring divider producing a fixed-point quotient
// floor(a*2^FRAC_BITS / b) and remainder (a*2^FRAC_BITS) mod b.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fixed_point_divider_if.slave (operand/result handshake)
// One quotient bit is resolved per cycle, so a nonzero divisor takes Q_W
// cycles from acceptance to valid_o. A zero divisor short-circuits: it spends
// a single cycle (ready_o low, no iterations) and then presents an all-ones
// quotient, remainder = a and div_by_zero = 1.
// -----------------------------------------------------------------------------
module fixed_point_divider #(
    parameter int WORD_LENGTH = 16,
    parameter int FRAC_BITS   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fixed_point_divider_if.slave   bus
);
    localparam int Q_W   = WORD_LENGTH + FRAC_BITS;
    localparam int CNT_W = $clog2(Q_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(Q_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [WORD_LENGTH-1:0] a_q;
    logic [WORD_LENGTH-1:0] b_q;
    logic [Q_W-1:0]         dvd_q;     // dividend bits still to be consumed, MSB first
    logic [WORD_LENGTH-1:0] rem_q;     // partial remainder, always < b between steps
    logic [Q_W-1:0]         quo_q;
    logic                   zero_pend_q;
    logic [Q_W-1:0]         quotient_q;
    logic [WORD_LENGTH-1:0] remainder_q;
    logic                   dbz_q;
    logic                   valid_q;
    logic                   ready_q;

    logic [WORD_LENGTH:0]   shifted_d;
    logic [WORD_LENGTH:0]   diff_d;
    logic                   ge_d;
    logic [WORD_LENGTH-1:0] rem_d;
    logic [Q_W-1:0]         quo_d;

    // One restoring step: shift in the next dividend bit, trial-subtract b.
    // The shifted value is below 2*b, so the W+1-bit difference cannot wrap
    // and its MSB is a clean borrow flag.
    always_comb begin
        shifted_d = {rem_q, dvd_q[Q_W-1]};
        diff_d    = shifted_d - {1'b0, b_q};
        ge_d      = ~diff_d[WORD_LENGTH];
        if (ge_d) begin
            rem_d = diff_d[WORD_LENGTH-1:0];
        end else begin
            rem_d = shifted_d[WORD_LENGTH-1:0];
        end
        quo_d = {quo_q[Q_W-2:0], ge_d};
    end

    // Control FSM plus datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            zero_pend_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (zero_pend_q) begin
                        // Second cycle of a divide-by-zero request.
                        zero_pend_q <= 1'b0;
                        quotient_q  <= '1;
                        remainder_q <= a_q;
                        dbz_q       <= 1'b1;
                        valid_q     <= 1'b1;
                        state_q     <= DONE;
                    end else if (bus.valid_i) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        dvd_q   <= {bus.a, {FRAC_BITS{1'b0}}};
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        ready_q <= 1'b0;
                        if (bus.b == '0) begin
                            zero_pend_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    dvd_q <= {dvd_q[Q_W-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d;
                        dbz_q       <= 1'b0;
                        valid_q     <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    zero_pend_q <= 1'b0;
                    valid_q     <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o     = ready_q;
    assign bus.valid_o     = valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_divider
// Directed and randomised checks of fixed_point_divider (16.8 configuration).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fixed_point_divider;
    logic clk;
    logic rst;
    int   checks;
    int   passed;

    fixed_point_divider_if #(.WORD_LENGTH(16), .FRAC_BITS(8)) bus ();

    fixed_point_divider #(.WORD_LENGTH(16), .FRAC_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for ready_o, present operands for one edge, then scramble a/b.
    task automatic start(input logic [15:0] av, input logic [15:0] bv);
        int w;
        w = 0;
        while (bus.ready_o !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("ready_o before start", {63'd0, bus.ready_o}, 64'd1);
        bus.a       = av;
        bus.b       = bv;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.a       = ~av;
        bus.b       = ~bv;
    endtask

    // Issue one division, wait for the result, compare against floor model.
    task automatic run(input logic [15:0] av, input logic [15:0] bv, input bit release_it);
        int          lat;
        logic [23:0] num;
        logic [23:0] eq;
        logic [15:0] er;
        logic        ed;
        num = {av, 8'h00};
        if (bv == 16'd0) begin
            eq = 24'hFFFFFF;
            er = av;
            ed = 1'b1;
        end else begin
            eq = num / {8'h00, bv};
            er = 16'(num % {8'h00, bv});
            ed = 1'b0;
        end
        start(av, bv);
        lat = 0;
        while (bus.valid_o !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), (bv == 16'd0) ? 64'd1 : 64'd24);
        chk("quotient", {40'd0, bus.quotient}, {40'd0, eq});
        chk("remainder", {48'd0, bus.remainder}, {48'd0, er});
        chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, ed});
        if (release_it) begin
            bus.ready_i = 1'b1;
            @(negedge clk);
            bus.ready_i = 1'b0;
            chk("valid_o after release", {63'd0, bus.valid_o}, 64'd0);
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        checks      = 0;
        passed      = 0;
        rst         = 1'b1;
        bus.a       = 16'd0;
        bus.b       = 16'd0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("reset ready_o", {63'd0, bus.ready_o}, 64'd1);
        chk("reset valid_o", {63'd0, bus.valid_o}, 64'd0);
        chk("reset quotient", {40'd0, bus.quotient}, 64'd0);
        chk("reset remainder", {48'd0, bus.remainder}, 64'd0);
        chk("reset div_by_zero", {63'd0, bus.div_by_zero}, 64'd0);

        // Directed vectors
        run(16'd3, 16'd2, 1'b1);
        chk("3/2 quotient kept in IDLE", {40'd0, bus.quotient}, 64'h180);
        run(16'd1, 16'd3, 1'b1);
        run(16'hFFFF, 16'd1, 1'b1);
        run(16'h1234, 16'd0, 1'b1);
        chk("dbz flag kept in IDLE", {63'd0, bus.div_by_zero}, 64'd1);

        // Backpressure: hold DONE for 10 cycles while new operands are offered
        run(16'd100, 16'd7, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.a       = 16'd5;
            bus.b       = 16'd1;
            bus.valid_i = i[0];
            @(negedge clk);
            chk("bp valid_o", {63'd0, bus.valid_o}, 64'd1);
            chk("bp ready_o", {63'd0, bus.ready_o}, 64'd0);
            chk("bp quotient", {40'd0, bus.quotient}, 64'hE49);
            chk("bp remainder", {48'd0, bus.remainder}, 64'd1);
        end
        // Release with valid_i also high: that edge must not accept operands
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        chk("release valid_o", {63'd0, bus.valid_o}, 64'd0);
        chk("release ready_o", {63'd0, bus.ready_o}, 64'd1);
        @(negedge clk);
        chk("no accept on release edge", {63'd0, bus.ready_o}, 64'd1);
        chk("quotient kept after release", {40'd0, bus.quotient}, 64'hE49);

        // Reset at iteration 12 of 100/7
        start(16'd100, 16'd7);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midbusy rst valid_o", {63'd0, bus.valid_o}, 64'd0);
        chk("midbusy rst ready_o", {63'd0, bus.ready_o}, 64'd1);
        chk("midbusy rst quotient", {40'd0, bus.quotient}, 64'd0);
        chk("midbusy rst remainder", {48'd0, bus.remainder}, 64'd0);
        repeat (20) @(negedge clk);
        chk("no late valid after rst", {63'd0, bus.valid_o}, 64'd0);
        run(16'd100, 16'd7, 1'b1);

        // Reset in DONE with ready_i high discards the result
        run(16'd3, 16'd2, 1'b0);
        rst         = 1'b1;
        bus.ready_i = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        bus.ready_i = 1'b0;
        chk("done rst valid_o", {63'd0, bus.valid_o}, 64'd0);
        chk("done rst quotient", {40'd0, bus.quotient}, 64'd0);

        // Random back-to-back operands with corner-case classes mixed in
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 6))
                0: rb = 16'd1;
                1: rb = 16'hFFFF;
                2: ra = 16'd0;
                3: begin
                    if (rb == 16'd0) rb = 16'd1;
                    ra = 16'($urandom_range(0, int'(rb) - 1));
                end
                4: rb = ($urandom_range(0, 3) == 0) ? 16'd0 : rb;
                default: ra = ra;
            endcase
            run(ra, rb, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fixed_point_divider.md
FIXED_POINT_DIVIDER -- requirements
Module: fixed_point_divider

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16: width of dividend, divisor and remainder.
REQ-002 SHALL have parameter FRAC_BITS, default 8: fractional bits appended to the dividend; quotient width Q_W = WORD_LENGTH+FRAC_BITS.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have a  input  WORD_LENGTH  unsigned dividend.
REQ-006 SHALL have b  input  WORD_LENGTH  unsigned divisor.
REQ-007 SHALL have valid_i  input  1  operand-valid strobe.
REQ-008 SHALL have ready_o  output  1  divider can accept operands.
REQ-009 SHALL have quotient  output  Q_W  floor(a*2^FRAC_BITS / b).
REQ-010 SHALL have remainder  output  WORD_LENGTH  (a*2^FRAC_BITS) mod b.
REQ-011 SHALL have div_by_zero  output  1  result was produced with b==0.
REQ-012 SHALL have valid_o  output  1  result-valid.
REQ-013 SHALL have ready_i  input  1  downstream accepts result.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY, DONE; ready_o=1 only in IDLE, valid_o=1 only in DONE.
REQ-015 SHALL accept operands on an edge where state==IDLE and valid_i==1; a and b are registered then, and later changes to a/b/valid_i are ignored until the next acceptance.
REQ-016 SHALL, on acceptance with b!=0, enter BUSY and clear the iteration counter, partial remainder and quotient register.
REQ-017 SHALL, in BUSY, perform one radix-2 restoring step per cycle over the Q_W bits of {a, FRAC_BITS zeros}, MSB first: shift the next dividend bit into the partial remainder (WORD_LENGTH+1 bits wide), subtract b if the result >= b, and shift the comparison bit into the quotient LSB.
REQ-018 SHALL complete exactly Q_W iterations: if acceptance is at edge E, state becomes DONE and valid_o rises after edge E+Q_W.
REQ-019 SHALL, on acceptance with b==0, go directly to DONE after edge E+1 with quotient = all ones, remainder = a, div_by_zero=1; no BUSY cycles.
REQ-020 SHALL keep div_by_zero=0 for every b!=0 result.
REQ-021 SHALL hold quotient, remainder and div_by_zero stable for the whole DONE state, however long ready_i stays low.
REQ-022 SHALL leave DONE for IDLE on the edge where valid_o==1 and ready_i==1; no operand is accepted on that same edge (ready_o was 0).
REQ-023 SHALL keep the last quotient/remainder/div_by_zero values on the outputs in IDLE until the next result overwrites them.
REQ-024 SHALL ignore valid_i in BUSY and DONE; no queuing of a second request.
REQ-025 SHALL never overflow: Q_W quotient bits and a WORD_LENGTH-bit remainder suffice for all inputs with b>=1.

Reset
REQ-026 SHALL, when rst==1 at a rising edge, force state to IDLE, counter to 0, quotient=0, remainder=0, div_by_zero=0, valid_o=0; ready_o=1 from the following cycle.
REQ-027 SHALL give rst priority over every other event, including mid-BUSY and DONE-with-ready_i; any in-flight result is discarded with no valid_o pulse.

Verification
REQ-028 SHALL cover WORD_LENGTH=16, FRAC_BITS=8: a=3, b=2 -> after 24 cycles valid_o=1, quotient=0x000180, remainder=0, div_by_zero=0.
REQ-029 SHALL cover a=1, b=3 -> quotient=0x000055, remainder=1; a=0xFFFF, b=1 -> quotient=0xFFFF00, remainder=0.
REQ-030 SHALL cover a=0x1234, b=0 -> valid_o after 1 cycle, quotient=0xFFFFFF, remainder=0x1234, div_by_zero=1.
REQ-031 SHALL cover backpressure: hold ready_i=0 for 10 cycles in DONE -> outputs constant, ready_o=0, valid_i pulses with new operands ignored; ready_i=1 -> IDLE next edge.
REQ-032 SHALL cover rst=1 at iteration 12 of a=100, b=7 -> next cycle valid_o=0, outputs 0, ready_o=1; a new request a=100, b=7 then yields quotient=0x000E49, remainder=1.
REQ-033 SHALL cover a 1000-operand random back-to-back test against a floor(a*256/b) reference model, including b=1, b=0xFFFF, a=0 and a<b.
